// File: rtl/nsc8_control_sequencer.sv
// NSC-8 fetch/decode/execute sequencer.
// Owns IR and decodes every bus strobe from state and opcode.
module nsc8_control_sequencer #(
  parameter int X = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [X-1:0] bus_in,
  input  logic         zero_flag,
  output logic [X-1:0] ir_operand,
  output logic         pc_out_en,
  output logic         pc_inc,
  output logic         pc_load,
  output logic         mar_load,
  output logic         ram_out_en,
  output logic         ram_write,
  output logic         ir_out_en,
  output logic         load_a,
  output logic         load_immediate_a,
  output logic         a_out_en,
  output logic         b_load,
  output logic         alu_sub,
  output logic         alu_out_en,
  output logic         flags_load,
  output logic         halted,
  output logic [2:0]   t_state
);

  localparam int H = X / 2;

  localparam logic [H-1:0] OP_LDA = H'(1);
  localparam logic [H-1:0] OP_ADD = H'(2);
  localparam logic [H-1:0] OP_SUB = H'(3);
  localparam logic [H-1:0] OP_STA = H'(4);
  localparam logic [H-1:0] OP_LDI = H'(5);
  localparam logic [H-1:0] OP_JMP = H'(6);
  localparam logic [H-1:0] OP_JZ  = H'(7);
  localparam logic [H-1:0] OP_HLT = H'(15);

  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  typedef struct packed {
    logic pc_out_en;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out_en;
    logic ram_write;
    logic ir_out_en;
    logic load_a;
    logic load_immediate_a;
    logic a_out_en;
    logic b_load;
    logic alu_sub;
    logic alu_out_en;
    logic flags_load;
  } ctrl_t;

  state_t       state, state_nxt;
  logic [X-1:0] ir;
  logic [H-1:0] opcode;
  logic         is_sub;
  ctrl_t        c, c_out;

  assign opcode = ir[X-1:H];
  assign is_sub = (opcode == OP_SUB);

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= S_T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_T1)
        ir <= bus_in;
    end
  end

  always_comb begin
    c         = '0;
    state_nxt = state;
    unique case (state)
      S_T0: begin
        c.pc_out_en = 1'b1;
        c.mar_load  = 1'b1;
        state_nxt   = S_T1;
      end
      S_T1: begin
        c.ram_out_en = 1'b1;
        c.pc_inc     = 1'b1;
        state_nxt    = S_T2;
      end
      S_T2: begin
        state_nxt = S_T0;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            c.ir_out_en = 1'b1;
            c.mar_load  = 1'b1;
            state_nxt   = S_T3;
          end
          OP_LDI: begin
            c.ir_out_en        = 1'b1;
            c.load_immediate_a = 1'b1;
          end
          OP_JMP: begin
            c.ir_out_en = 1'b1;
            c.pc_load   = 1'b1;
          end
          OP_JZ: begin
            c.ir_out_en = zero_flag;
            c.pc_load   = zero_flag;
          end
          OP_HLT: state_nxt = S_HALT;
          default: ;
        endcase
      end
      S_T3: begin
        state_nxt = S_T0;
        case (opcode)
          OP_LDA: begin
            c.ram_out_en = 1'b1;
            c.load_a     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            c.ram_out_en = 1'b1;
            c.b_load     = 1'b1;
            c.alu_sub    = is_sub;
            state_nxt    = S_T4;
          end
          OP_STA: begin
            c.a_out_en  = 1'b1;
            c.ram_write = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        c.alu_out_en = 1'b1;
        c.load_a     = 1'b1;
        c.flags_load = 1'b1;
        c.alu_sub    = is_sub;
        state_nxt    = S_T0;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_T0;
    endcase
  end

  // Clear silences every strobe so nothing fights on the bus
  assign c_out = clear ? '0 : c;

  assign pc_out_en        = c_out.pc_out_en;
  assign pc_inc           = c_out.pc_inc;
  assign pc_load          = c_out.pc_load;
  assign mar_load         = c_out.mar_load;
  assign ram_out_en       = c_out.ram_out_en;
  assign ram_write        = c_out.ram_write;
  assign ir_out_en        = c_out.ir_out_en;
  assign load_a           = c_out.load_a;
  assign load_immediate_a = c_out.load_immediate_a;
  assign a_out_en         = c_out.a_out_en;
  assign b_load           = c_out.b_load;
  assign alu_sub          = c_out.alu_sub;
  assign alu_out_en       = c_out.alu_out_en;
  assign flags_load       = c_out.flags_load;

  assign ir_operand = {{(X-H){1'b0}}, ir[H-1:0]};
  assign halted     = (state == S_HALT);
  assign t_state    = state;

endmodule

// File: tb/tb_nsc8_control_sequencer.sv
// Bench for nsc8_control_sequencer.
// Model lists the strobes of each instruction step by step.
module tb_nsc8_control_sequencer;

  localparam logic [13:0] PCO  = 14'h2000;
  localparam logic [13:0] PCI  = 14'h1000;
  localparam logic [13:0] PCL  = 14'h0800;
  localparam logic [13:0] MARL = 14'h0400;
  localparam logic [13:0] RAMO = 14'h0200;
  localparam logic [13:0] RAMW = 14'h0100;
  localparam logic [13:0] IRO  = 14'h0080;
  localparam logic [13:0] LDA  = 14'h0040;
  localparam logic [13:0] LDI  = 14'h0020;
  localparam logic [13:0] AO   = 14'h0010;
  localparam logic [13:0] BL   = 14'h0008;
  localparam logic [13:0] SUB  = 14'h0004;
  localparam logic [13:0] ALUO = 14'h0002;
  localparam logic [13:0] FL   = 14'h0001;

  logic       clk = 1'b0;
  logic       clear;
  logic [7:0] bus_in;
  logic       zero_flag;
  logic [7:0] ir_operand;
  logic       pc_out_en, pc_inc, pc_load, mar_load;
  logic       ram_out_en, ram_write, ir_out_en;
  logic       load_a, load_immediate_a, a_out_en;
  logic       b_load, alu_sub, alu_out_en, flags_load;
  logic       halted;
  logic [2:0] t_state;

  nsc8_control_sequencer #(.X(8)) dut (
    .clk              (clk),
    .clear            (clear),
    .bus_in           (bus_in),
    .zero_flag        (zero_flag),
    .ir_operand       (ir_operand),
    .pc_out_en        (pc_out_en),
    .pc_inc           (pc_inc),
    .pc_load          (pc_load),
    .mar_load         (mar_load),
    .ram_out_en       (ram_out_en),
    .ram_write        (ram_write),
    .ir_out_en        (ir_out_en),
    .load_a           (load_a),
    .load_immediate_a (load_immediate_a),
    .a_out_en         (a_out_en),
    .b_load           (b_load),
    .alu_sub          (alu_sub),
    .alu_out_en       (alu_out_en),
    .flags_load       (flags_load),
    .halted           (halted),
    .t_state          (t_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] ctrl;
    bit          chk_t;
    logic [3:0]  ht;
    bit          chk_op;
    logic [7:0]  op;
  } exp_t;

  exp_t cur;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   first_halt = -1;
  int   n_lda = 0;
  int   n_fl = 0;
  logic [13:0] snap [0:7];
  logic [7:0]  snap_op [0:7];

  wire [13:0] dut_ctrl = {pc_out_en, pc_inc, pc_load, mar_load,
                          ram_out_en, ram_write, ir_out_en,
                          load_a, load_immediate_a, a_out_en,
                          b_load, alu_sub, alu_out_en, flags_load};

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int nd;
    if (chk_en) begin
      chk("ctrl", 16'(dut_ctrl), 16'(cur.ctrl));
      if (cur.chk_t)
        chk("state", 16'({halted, t_state}), 16'(cur.ht));
      if (cur.chk_op)
        chk("operand", 16'(ir_operand), 16'(cur.op));
      nd = int'(pc_out_en) + int'(ram_out_en) + int'(ir_out_en)
         + int'(a_out_en) + int'(alu_out_en);
      chk("bus_excl", 16'(nd > 1), 16'd0);
      chk("load_excl", 16'(load_a & load_immediate_a), 16'd0);
      chk("pc_excl", 16'(pc_inc & pc_load), 16'd0);
      snap[t_state]    = dut_ctrl;
      snap_op[t_state] = ir_operand;
      if (load_a) n_lda++;
      if (flags_load) n_fl++;
      if (halted && first_halt < 0) first_halt = cyc;
    end
    cyc++;
  end

  task automatic step(input logic [13:0] c, input logic [2:0] t,
                      input bit h = 1'b0, input bit op_en = 1'b0,
                      input logic [7:0] op = 8'h00);
    clear      = 1'b0;
    cur.ctrl   = c;
    cur.chk_t  = 1'b1;
    cur.ht     = {h, t};
    cur.chk_op = op_en;
    cur.op     = op;
    chk_en     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_step();
    clear      = 1'b1;
    cur.ctrl   = '0;
    cur.chk_t  = 1'b0;
    cur.chk_op = 1'b0;
    cur.op     = '0;
    chk_en     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [7:0] ins, input bit z,
                           input int max_steps = 99,
                           input bit skip_t0 = 1'b0);
    logic [3:0]  o;
    logic [7:0]  opd;
    logic [13:0] seq[$];
    int          n;
    o   = ins[7:4];
    opd = {4'h0, ins[3:0]};
    bus_in    = ins;
    zero_flag = z;
    seq.push_back(PCO | MARL);
    seq.push_back(RAMO | PCI);
    case (o)
      4'h1: begin
        seq.push_back(IRO | MARL);
        seq.push_back(RAMO | LDA);
      end
      4'h2, 4'h3: begin
        seq.push_back(IRO | MARL);
        seq.push_back(RAMO | BL | (o == 4'h3 ? SUB : 14'h0));
        seq.push_back(ALUO | LDA | FL | (o == 4'h3 ? SUB : 14'h0));
      end
      4'h4: begin
        seq.push_back(IRO | MARL);
        seq.push_back(AO | RAMW);
      end
      4'h5: seq.push_back(IRO | LDI);
      4'h6: seq.push_back(IRO | PCL);
      4'h7: seq.push_back(z ? (IRO | PCL) : 14'h0);
      default: seq.push_back(14'h0);
    endcase
    n = (seq.size() < max_steps) ? seq.size() : max_steps;
    for (int i = int'(skip_t0); i < n; i++)
      step(seq[i], 3'(i), 1'b0, (seq[i] & IRO) != 0, opd);
  endtask

  task automatic halt_steps(input int n);
    for (int i = 0; i < n; i++)
      step(14'h0, 3'd7, 1'b1);
  endtask

  logic [7:0] prog [0:2];
  int mark, la0, fl0;

  initial begin
    clear     = 1'b1;
    bus_in    = 8'h00;
    zero_flag = 1'b0;
    cur       = '{default: '0};
    repeat (2) @(posedge clk);
    #1;
    clear_step();
    clear_step();
    step(PCO | MARL, 3'd0, 1'b0, 1'b1, 8'h00);
    run_instr(8'h00, 1'b0, 99, 1'b1);

    run_instr(8'h3A, 1'b0);
    chk("sub_t3", 16'(snap[3]), 16'(RAMO | BL | SUB));
    chk("sub_t4", 16'(snap[4]), 16'(ALUO | LDA | FL | SUB));
    step(PCO | MARL, 3'd0);
    run_instr(8'h59, 1'b0, 99, 1'b1);
    chk("ldi_t2", 16'(snap[2]), 16'(IRO | LDI));
    chk("ldi_op", 16'(snap_op[2]), 16'h0009);
    run_instr(8'h74, 1'b0);
    chk("jz0_t2", 16'(snap[2]), 16'h0000);
    run_instr(8'h74, 1'b1);
    chk("jz1_t2", 16'(snap[2]), 16'(IRO | PCL));
    chk("jz1_op", 16'(snap_op[2]), 16'h0004);
    run_instr(8'h1E, 1'b0);
    run_instr(8'h47, 1'b1);
    run_instr(8'h63, 1'b0);
    run_instr(8'h8A, 1'b1);
    run_instr(8'hE5, 1'b0);

    run_instr(8'h2F, 1'b0, 3);
    clear_step();
    clear_step();
    step(PCO | MARL, 3'd0, 1'b0, 1'b1, 8'h00);
    run_instr(8'h00, 1'b0, 99, 1'b1);

    prog[0] = 8'h1E;
    prog[1] = 8'h2F;
    prog[2] = 8'hF0;
    clear_step();
    clear_step();
    mark       = cyc;
    first_halt = -1;
    la0        = n_lda;
    fl0        = n_fl;
    for (int i = 0; i < 3; i++)
      run_instr(prog[i], 1'b0);
    halt_steps(21);
    chk("halt_cycle", 16'(first_halt - mark), 16'd12);
    chk("lda_pulses", 16'(n_lda - la0), 16'd2);
    chk("fl_pulses", 16'(n_fl - fl0), 16'd1);

    clear_step();
    clear_step();
    for (int i = 0; i < 1000; i++) begin
      logic [3:0] o;
      logic [3:0] a;
      o = 4'($urandom_range(0, 14));
      a = 4'($urandom_range(0, 15));
      run_instr({o, a}, 1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nsc8_control_sequencer.md
Name: nsc8_control_sequencer

Overview:
- Fetch/decode/execute state machine for the NSC-8 single-bus CPU.
- Owns the instruction register (IR).
- Drives every load, output-enable and strobe for the PC, MAR, RAM, accumulator (load_a, load_immediate_a, output_enable), B register, ALU and flag register.
- Guarantees at most one bus driver per cycle.

Parameters:
- X, 8, data/bus width; IR is X bits: opcode = IR[X-1:X/2], operand = IR[X/2-1:0].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clear  input  1  synchronous active-high reset.
- bus_in  input  X  shared data bus, sampled into IR.
- zero_flag  input  1  registered Z flag from the flag register.
- ir_operand  output  X  {X/2 zeros, IR[X/2-1:0]}; valid only when ir_out_en=1.
- pc_out_en  output  1  PC drives bus.
- pc_inc  output  1  PC increments at the edge.
- pc_load  output  1  PC loads from bus.
- mar_load  output  1  MAR loads from bus.
- ram_out_en  output  1  RAM[MAR] drives bus.
- ram_write  output  1  RAM[MAR] written from bus.
- ir_out_en  output  1  ir_operand drives bus.
- load_a  output  1  accumulator loads full byte.
- load_immediate_a  output  1  accumulator loads lower nibble and clears upper nibble.
- a_out_en  output  1  accumulator drives bus.
- b_load  output  1  B register loads from bus.
- alu_sub  output  1  ALU subtract select.
- alu_out_en  output  1  ALU result drives bus.
- flags_load  output  1  flag register captures ALU flags.
- halted  output  1  CPU stopped.
- t_state  output  3  current T-step, for debug.

Behaviour:
- States: T0, T1, T2, T3, T4, HALT (encoding free; t_state reports 0–4, and 7 in HALT).
- Control outputs are a combinational decode of state and IR. The consuming register acts at the rising edge that ends the cycle.
- Reset: clear=1 forces all control outputs to 0 in the same cycle (no bus contention). At the edge: state=T0, IR=0, halted=0. Reset takes effect from any state, including HALT and mid-instruction; the partial instruction is abandoned.
- T0: pc_out_en, mar_load → T1.
- T1: ram_out_en, pc_inc; IR<=bus_in at the edge → T2.
- Execute steps by opcode:
  - 0x0 NOP: T2 none.
  - 0x1 LDA: T2 ir_out_en+mar_load; T3 ram_out_en+load_a.
  - 0x2 ADD: T2 ir_out_en+mar_load; T3 ram_out_en+b_load; T4 alu_out_en+load_a+flags_load, alu_sub=0.
  - 0x3 SUB: as ADD, but alu_sub=1 in T3 and T4.
  - 0x4 STA: T2 ir_out_en+mar_load; T3 a_out_en+ram_write.
  - 0x5 LDI: T2 ir_out_en+load_immediate_a.
  - 0x6 JMP: T2 ir_out_en+pc_load.
  - 0x7 JZ: T2 ir_out_en+pc_load only if zero_flag=1 (sampled in T2); otherwise no outputs.
  - 0xF HLT: T2 → HALT.
  - 0x8–0xE: undefined; treated as NOP.
- Transitions: after the last execute step the state returns to T0. Cycle counts: NOP/LDI/JMP/JZ/undefined = 3; LDA/STA = 4; ADD/SUB = 5.
- HALT: all control outputs 0, halted=1, IR held. Exits only via clear.
- Invariant: at most one of pc_out_en, ram_out_en, ir_out_en, a_out_en, alu_out_en is high in any cycle.
- Invariant: load_a and load_immediate_a are never high together.
- pc_inc and pc_load are never high together.
- Operand addressing reaches only addresses 0–15. PC wrap-around is the PC's concern; no special handling here.

Test Plan:
- clear held 2 cycles mid-ADD (T3) → outputs 0 during clear; next cycle t_state=0 with pc_out_en=1 and mar_load=1; IR=0x00.
- RAM {0:0x1E, 1:0x2F, 2:0xF0, 14:0x05, 15:0x03} → after LDA 14, ADD 15: one load_a pulse per instruction in T3/T4, flags_load once. halted=1 at cycle 12 and stays 1 for 20 further cycles.
- IR=0x3A (SUB 10) → T3: ram_out_en=1, b_load=1, alu_sub=1; T4: alu_out_en=1, load_a=1, flags_load=1, alu_sub=1; next state T0.
- IR=0x59 (LDI 9) → T2: ir_out_en=1, load_immediate_a=1, ir_operand=0x09, load_a=0; 3-cycle instruction.
- IR=0x74 (JZ 4): zero_flag=0 → T2 with no outputs; zero_flag=1 → ir_out_en=1, pc_load=1, ir_operand=0x04.
- Random opcode stream (1000 instructions, including 0x8–0xE) → bus-exclusivity and load-exclusivity invariants never violated; undefined opcodes take 3 cycles with no strobes in T2.
